// File: rtl/apuf_ctrl_pkg.sv
// Shared types and constants for the arbiter-PUF evaluation sequencer.
package apuf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RACE,
        SAMPLE,
        RECOVER,
        DONE
    } apuf_state_e;

    localparam int APUF_CHAL_W   = 45;
    localparam int APUF_NUM_EVAL = 7;

    // Accept-to-resp_valid latency in clk cycles.
    function automatic int apuf_latency(input int settle, input int race, input int n_eval);
        return settle + n_eval * (race + 1 + settle) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF sequencer: holds a challenge, fires NUM_EVAL races and
// returns a majority-voted response with a ones count and stability flag.
module apuf_eval_ctrl
    import apuf_ctrl_pkg::*;
#(
    parameter int CHAL_W     = APUF_CHAL_W,
    parameter int SETTLE_CYC = 4,
    parameter int RACE_CYC   = 4,
    parameter int NUM_EVAL   = APUF_NUM_EVAL,
    parameter int CNT_W      = $clog2(NUM_EVAL + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHAL_W-1:0] chal_in,
    input  logic              chal_valid,
    output logic              chal_ready,
    output logic [CHAL_W-1:0] puf_chal,
    output logic              puf_x,
    output logic              puf_y,
    input  logic              puf_q,
    output logic              resp_bit,
    output logic [CNT_W-1:0]  resp_ones,
    output logic              resp_stable,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy
);

    localparam int CYC_MAX = (SETTLE_CYC > RACE_CYC) ? SETTLE_CYC : RACE_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [CYC_W-1:0] SETTLE_LD = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] RACE_LD   = CYC_W'(RACE_CYC - 1);
    localparam logic [CNT_W-1:0] NE        = CNT_W'(NUM_EVAL);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(NUM_EVAL / 2);

    apuf_state_e      state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] eval_q, ones_q;
    logic             xy_q;
    logic             q_sync;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (puf_q),
        .q     (q_sync)
    );

    assign chal_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign puf_x      = xy_q;
    assign puf_y      = xy_q;

    // One down-counter serves SETUP, RACE and RECOVER; reloaded on entry.
    always_comb begin
        state_d = state_q;
        cyc_d   = (cyc_q != '0) ? cyc_q - CYC_W'(1) : cyc_q;
        case (state_q)
            IDLE:    if (chal_valid) begin
                         state_d = SETUP;
                         cyc_d   = SETTLE_LD;
                     end
            SETUP:   if (cyc_q == '0) begin
                         state_d = RACE;
                         cyc_d   = RACE_LD;
                     end
            RACE:    if (cyc_q == '0) state_d = SAMPLE;
            SAMPLE:  begin
                         state_d = RECOVER;
                         cyc_d   = SETTLE_LD;
                     end
            RECOVER: if (cyc_q == '0) begin
                         if (eval_q == NE) begin
                             state_d = DONE;
                         end else begin
                             state_d = RACE;
                             cyc_d   = RACE_LD;
                         end
                     end
            DONE:    if (resp_valid && resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            xy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            // X/Y stay high through the SAMPLE cycle and drop on entering RECOVER.
            xy_q    <= (state_d == RACE) || (state_d == SAMPLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            puf_chal    <= '0;
            eval_q      <= '0;
            ones_q      <= '0;
            resp_valid  <= 1'b0;
            resp_bit    <= 1'b0;
            resp_ones   <= '0;
            resp_stable <= 1'b0;
        end else begin
            if (state_q == IDLE && chal_valid) begin
                puf_chal <= chal_in;
                eval_q   <= '0;
                ones_q   <= '0;
            end
            if (state_q == SAMPLE) begin
                eval_q <= eval_q + CNT_W'(1);
                if (ones_q != NE) ones_q <= ones_q + CNT_W'(q_sync);
            end
            if (state_q == DONE && !resp_valid) begin
                resp_valid  <= 1'b1;
                resp_ones   <= ones_q;
                resp_bit    <= (ones_q > HALF);
                resp_stable <= (ones_q == '0) || (ones_q == NE);
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Self-checking bench for apuf_eval_ctrl: default build plus a NUM_EVAL=1 build.
module tb_apuf_eval_ctrl;

    typedef struct packed {
        logic       rbit;
        logic [2:0] ones;
        logic       stable;
    } exp_t;

    typedef struct {
        logic [44:0] chal;
        logic [6:0]  pat;
        exp_t        e;
        int          bp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [44:0] chal_in = '0;
    logic        chal_valid = 1'b0;
    logic        chal_ready;
    logic [44:0] puf_chal;
    logic        puf_x, puf_y;
    logic        puf_q = 1'b0;
    logic        resp_bit;
    logic [2:0]  resp_ones;
    logic        resp_stable, resp_valid;
    logic        resp_ready = 1'b1;
    logic        busy;

    logic [44:0] chal_in_1 = '0;
    logic        chal_valid_1 = 1'b0;
    logic        chal_ready_1;
    logic [44:0] puf_chal_1;
    logic        puf_x_1, puf_y_1;
    logic        puf_q_1 = 1'b0;
    logic        resp_bit_1;
    logic [0:0]  resp_ones_1;
    logic        resp_stable_1, resp_valid_1;
    logic        resp_ready_1 = 1'b1;
    logic        busy_1;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   rises, eval_k;
    bit   xy_bad, x_prev;

    always #5 clk = ~clk;

    apuf_eval_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .chal_in(chal_in), .chal_valid(chal_valid),
        .chal_ready(chal_ready), .puf_chal(puf_chal), .puf_x(puf_x), .puf_y(puf_y),
        .puf_q(puf_q), .resp_bit(resp_bit), .resp_ones(resp_ones),
        .resp_stable(resp_stable), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .busy(busy)
    );

    apuf_eval_ctrl #(.CHAL_W(45), .SETTLE_CYC(1), .RACE_CYC(3), .NUM_EVAL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .chal_in(chal_in_1), .chal_valid(chal_valid_1),
        .chal_ready(chal_ready_1), .puf_chal(puf_chal_1), .puf_x(puf_x_1), .puf_y(puf_y_1),
        .puf_q(puf_q_1), .resp_bit(resp_bit_1), .resp_ones(resp_ones_1),
        .resp_stable(resp_stable_1), .resp_valid(resp_valid_1), .resp_ready(resp_ready_1),
        .busy(busy_1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // PUF model: a new Q value from the pattern on every rising race edge.
    task automatic model_step(input logic [6:0] pat);
        if (puf_x && !x_prev) begin
            rises++;
            puf_q = (eval_k < 7) ? pat[eval_k] : 1'b0;
            eval_k++;
        end
        if (puf_x !== puf_y) xy_bad = 1'b1;
        x_prev = puf_x;
    endtask

    task automatic run_txn(input logic [44:0] chal, input logic [6:0] pat,
                           input exp_t e, input int bp);
        int   cyc;
        bit   seen, chal_bad, hold_bad;
        exp_t got, want;
        resp_ready = (bp == 0);
        rises = 0; eval_k = 0; xy_bad = 1'b0; x_prev = puf_x;
        chal_bad = 1'b0; hold_bad = 1'b0; seen = 1'b0;
        chk("accept_ready", chal_ready, 1'b1);
        chal_in = chal; chal_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        chal_valid = 1'b0;
        cyc = 0;
        while (!seen && cyc < 200) begin
            if (resp_valid) seen = 1'b1;
            else begin
                if (puf_chal !== chal) chal_bad = 1'b1;
                model_step(pat);
                @(negedge clk);
                cyc++;
            end
        end
        chk("latency", cyc, 68);
        chk("x_rises", rises, 7);
        chk("xy_together", xy_bad, 1'b0);
        chk("chal_hold", chal_bad, 1'b0);
        got  = '{rbit: resp_bit, ones: resp_ones, stable: resp_stable};
        want = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("resp_bit", got.rbit, want.rbit);
        chk("resp_ones", got.ones, want.ones);
        chk("resp_stable", got.stable, want.stable);
        for (int i = 0; i < bp; i++) begin
            chal_in = ~chal; chal_valid = 1'b1;
            @(negedge clk);
            if (!resp_valid || chal_ready || !busy || puf_chal !== chal ||
                resp_bit !== got.rbit || resp_ones !== got.ones ||
                resp_stable !== got.stable) hold_bad = 1'b1;
        end
        if (bp > 0) chk("backpressure_hold", hold_bad, 1'b0);
        chal_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", resp_valid, 1'b0);
        chk("post_hs_ready", chal_ready, 1'b1);
    endtask

    task automatic run1(input logic q, input logic [44:0] chal);
        int   cyc;
        exp_t want;
        puf_q_1 = q;
        chal_in_1 = chal; chal_valid_1 = 1'b1;
        @(posedge clk);
        sb.push_back('{rbit: q, ones: {2'b00, q}, stable: 1'b1});
        @(negedge clk);
        chal_valid_1 = 1'b0;
        cyc = 0;
        while (!resp_valid_1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        want = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("n1_latency", cyc, 7);
        chk("n1_resp_bit", resp_bit_1, want.rbit);
        chk("n1_resp_ones", resp_ones_1, want.ones[0]);
        chk("n1_resp_stable", resp_stable_1, want.stable);
        @(negedge clk);
        chk("n1_post_hs", {resp_valid_1, chal_ready_1}, 2'b01);
    endtask

    vec_t tv[6];

    initial begin
        int  cyc;
        bit  hit, leak;
        tv[0] = '{45'h1_2345_6789_AB, 7'b1111111, '{1'b1, 3'd7, 1'b1}, 0};
        tv[1] = '{45'h0_0F0F_F0F0_11, 7'b1001101, '{1'b1, 3'd4, 1'b0}, 0};
        tv[2] = '{45'h1_FFFF_0000_FF, 7'b0100100, '{1'b0, 3'd2, 1'b0}, 10};
        tv[3] = '{45'h0_0000_0000_01, 7'b0000000, '{1'b0, 3'd0, 1'b1}, 0};
        tv[4] = '{45'h1_5555_AAAA_55, 7'b0111111, '{1'b1, 3'd6, 1'b0}, 3};
        tv[5] = '{45'h0_DEAD_BEEF_00, 7'b0111000, '{1'b0, 3'd3, 1'b0}, 0};

        repeat (3) @(negedge clk);
        chk("rst_outputs", {chal_ready, puf_x, puf_y, resp_valid, busy}, 5'b10000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {chal_ready, puf_x, puf_y, resp_valid, busy}, 5'b10000);
        chk("idle_resp", {resp_bit, resp_ones, resp_stable}, 5'b0);
        chk("idle_chal", puf_chal, 45'h0);

        for (int i = 0; i < 6; i++) run_txn(tv[i].chal, tv[i].pat, tv[i].e, tv[i].bp);

        // Reset while X is high in the third evaluation.
        rises = 0; eval_k = 0; xy_bad = 1'b0; x_prev = puf_x; hit = 1'b0;
        chal_in = 45'h0_0000_0ABC_DE; chal_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{1'b1, 3'd7, 1'b1});
        @(negedge clk);
        chal_valid = 1'b0;
        cyc = 0;
        while (!hit && cyc < 300) begin
            model_step(7'b1111111);
            if (rises == 3 && puf_x) hit = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("reach_3rd_race", hit, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_xy", {puf_x, puf_y}, 2'b00);
        chk("midrst_state", {busy, chal_ready, resp_valid}, 3'b010);
        chk("midrst_chal", puf_chal, 45'h0);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        leak = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid || busy) leak = 1'b1;
        end
        chk("no_partial_resp", leak, 1'b0);
        run_txn(45'h0_0000_0ABC_DE, 7'b0100100, '{1'b0, 3'd2, 1'b0}, 0);

        run1(1'b1, 45'h1_0000_0000_01);
        run1(1'b0, 45'h0_1234_0000_00);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apuf_eval_ctrl.md
Name: apuf_eval_ctrl

Overview:
- Sequencer for one 45-stage arbiter-PUF instance.
- Accepts a challenge over a valid/ready handshake and drives the challenge bits to the PUF.
- Fires the X/Y race edge NUM_EVAL times, sampling the arbiter output once per fire.
- Returns a majority-voted response bit, the ones count and a stability flag over a valid/ready handshake.

Parameters:
- CHAL_W, 45: challenge width; matches the PUF stage count (size_of+1).
- SETTLE_CYC, 4: cycles with X=Y=0 and the challenge stable before each launch; also the recovery time after each race. Minimum 1.
- RACE_CYC, 4: cycles X=Y=1 is held before the arbiter output is sampled. Minimum 3, which covers the 2-flop synchronizer.
- NUM_EVAL, 7: evaluations per challenge. Must be odd and at least 1.
- CNT_W, $clog2(NUM_EVAL+1): width of the ones counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- chal_in  in  CHAL_W  challenge from requester
- chal_valid  in  1  challenge valid
- chal_ready  out  1  controller can accept a challenge
- puf_chal  out  CHAL_W  to PUF Chal
- puf_x  out  1  to PUF X (race input, top path)
- puf_y  out  1  to PUF Y (race input, bottom path)
- puf_q  in  1  PUF out_Q; asynchronous to clk
- resp_bit  out  1  majority-voted response
- resp_ones  out  CNT_W  number of evaluations that returned 1
- resp_stable  out  1  1 when all evaluations agree (ones is 0 or NUM_EVAL)
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous assert and synchronous-to-clk deassert:
  - state=IDLE; chal_ready=1; puf_chal=0; puf_x=puf_y=0.
  - resp_valid=0; resp_bit=0; resp_ones=0; resp_stable=0; busy=0.
  - All counters and both synchronizer flops cleared.
- puf_x and puf_y are registered and always driven from a single flop, so they toggle in the same cycle.
- puf_q passes through a 2-flop synchronizer; q_sync lags puf_q by 2 clk edges.
- IDLE: chal_ready=1. On chal_valid&&chal_ready, register chal_in into puf_chal, clear the eval counter and ones counter, go to SETUP.
- SETUP: X=Y=0 for SETTLE_CYC cycles, then go to RACE and set X=Y=1.
- RACE: hold X=Y=1 for RACE_CYC cycles, then go to SAMPLE.
- SAMPLE: one cycle.
  - ones += q_sync.
  - eval += 1.
  - Set X=Y=0 and go to RECOVER.
- RECOVER: X=Y=0 for SETTLE_CYC cycles, so the DFF clock path falls before the next rising race.
  - If eval==NUM_EVAL, go to DONE.
  - Otherwise go directly to RACE (X=Y=1). The challenge is unchanged, so no extra SETUP is needed.
- DONE:
  - resp_valid=1, resp_ones=ones, resp_bit=(ones > NUM_EVAL/2), resp_stable=(ones==0 || ones==NUM_EVAL).
  - Outputs hold steady while resp_valid && !resp_ready.
  - On resp_ready, drop resp_valid and go to IDLE; chal_ready rises the following cycle.
- puf_chal stays constant from challenge accept until return to IDLE. It never changes while X or Y is 1.
- Latency from accept to resp_valid = SETTLE_CYC + NUM_EVAL*(RACE_CYC+1+SETTLE_CYC) + 1 cycles. Defaults: 4+7*9+1 = 68.
- chal_valid is ignored while busy. It is not queued; the requester holds it until chal_ready.
- Reset mid-operation: immediate return to reset values, X=Y=0. No partial response is emitted.
- The ones counter saturates at NUM_EVAL and never wraps.

Decomposition:
- Package apuf_ctrl_pkg:
  - state enum {IDLE, SETUP, RACE, SAMPLE, RECOVER, DONE}.
  - Default constants APUF_CHAL_W=45, APUF_NUM_EVAL=7.
  - Latency helper function.
- Sub-module sync_2ff: 2-flop synchronizer with async active-low clear; used for puf_q.
- A single cycle counter is shared across SETUP, RACE and RECOVER, reloaded on each state entry.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> chal_ready=1, puf_x=puf_y=0, resp_valid=0, busy=0.
- Stable 1, model PUF always returns Q=1, chal_in=45'h1_2345_6789_AB, resp_ready=1:
  - puf_chal=45'h1_2345_6789_AB from the cycle after accept to end of operation.
  - resp_valid exactly 68 cycles after accept.
  - resp_bit=1, resp_ones=7, resp_stable=1.
  - Exactly 7 rising edges on puf_x, each coincident with puf_y.
- Noisy PUF returns 1,0,1,1,0,0,1 over the evaluations -> resp_ones=4, resp_bit=1, resp_stable=0. With pattern 0,0,1,0,0,1,0 -> ones=2, resp_bit=0.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> outputs constant, chal_ready=0, new chal_valid ignored. Raise resp_ready -> one-cycle handshake, then IDLE with chal_ready=1.
- Reset mid-race: assert rst_n=0 while puf_x=1 during the 3rd evaluation -> puf_x=puf_y=0 and state IDLE immediately. No resp_valid pulse; next challenge completes normally with a fresh count.
- Parameter sweep NUM_EVAL=1, RACE_CYC=3, SETTLE_CYC=1 -> latency 1+1*(3+1+1)+1 = 7 cycles. resp_stable=1 always; resp_bit equals the single sample.
